id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary, directly downstream of the 32x32 register file.
- Latches both read ports, decoded fields and control bits into the EX stage.
- Compensates for the register file's edge-triggered write. A WB write to a register in the same cycle that ID reads it returns the stale value, so this block substitutes the WB data.
- Supports stall (hold) and flush (bubble insert), and counts bubbles for performance monitoring.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register index width
- CTRL_W, 10, packed control-bit bundle width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous reset, active-low
- stall  in  1  hold all EX outputs this cycle
- flush  in  1  load a bubble this cycle
- id_valid  in  1  ID holds a real instruction
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs  in  REG_AW  source register 1 index
- id_rt  in  REG_AW  source register 2 index
- id_rd  in  REG_AW  destination register index
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- rf_read_data1  in  DATA_W  register file port 1 (addressed by id_rs)
- rf_read_data2  in  DATA_W  register file port 2 (addressed by id_rt)
- wb_write_enable  in  1  WB write strobe, same signal that drives the register file
- wb_write_reg  in  REG_AW  WB destination index
- wb_write_data  in  DATA_W  WB data
- ex_valid  out  1  EX holds a real instruction
- ex_pc4  out  DATA_W  latched id_pc4
- ex_rs  out  REG_AW  latched id_rs
- ex_rt  out  REG_AW  latched id_rt
- ex_rd  out  REG_AW  latched id_rd
- ex_imm  out  DATA_W  latched id_imm
- ex_ctrl  out  CTRL_W  latched id_ctrl; all zero when bubble
- ex_a  out  DATA_W  operand A
- ex_b  out  DATA_W  operand B
- bubble_count  out  CNT_W  saturating bubble counter

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low. Sampled only on the rising edge of clk.
- Reset (reset=0 at edge): all ex_* outputs go to 0, including ex_valid=0 and ex_ctrl=0. bubble_count goes to 0. Reset overrides flush and stall.
- Edge priority when reset=1:
  - flush: bubble loaded. ex_valid=0, ex_ctrl=0; other ex_* fields go to 0.
  - else stall: every output register holds its value, including bubble_count.
  - else load: ex_valid<=id_valid and every field is latched. If id_valid=0, ex_ctrl is forced to 0 and the remaining fields are still latched.
- Latency: one cycle, ID to EX.
- Operand A selection, per port, evaluated at the load edge:
  - If wb_write_enable=1 and wb_write_reg==id_rs and id_rs!=0, then ex_a<=wb_write_data.
  - Otherwise ex_a<=rf_read_data1.
- Operand B: same rule using id_rt, rf_read_data2 and ex_b.
- Register 0 is never bypassed. A WB to index 0 has no effect on ex_a or ex_b.
- Both ports may bypass in the same cycle (id_rs==id_rt==wb_write_reg), and both receive wb_write_data.
- Stall with an active WB: the held values are not refreshed by the WB write. Forwarding those values is EX/MEM forwarding's responsibility and is out of scope for this block.
- bubble_count:
  - Increments by 1 on each non-reset edge that loads a bubble: flush=1, or (stall=0 and id_valid=0).
  - Saturates at 2^CNT_W-1; no wrap.
  - Holds during stall.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: the bypass described above is built.
- Undefined: ex_a and ex_b always latch rf_read_data1 and rf_read_data2. The integrating design must then use a write-first register file or stall on the conflict.
- wb_* ports exist in both builds; they are unused when the macro is undefined.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W, REG_AW and the ZERO_REG constant
  - CTRL_W, plus the ctrl bit index constants: CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_ALUSRC, CTRL_REGDST, CTRL_BRANCH, CTRL_ALUOP_LSB/MSB
- Sub-module wb_bypass_sel: combinational, one operand. Inputs are index, rf data and the three wb_* signals; output is the selected data. Instantiated twice. The macro gates its use.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> all outputs 0 and bubble_count=0. Release, load id_pc4=0x00400004, id_valid=1 -> ex_pc4=0x00400004 and ex_valid=1 one cycle later.
- Bypass (macro on): id_rs=8, rf_read_data1=0x11111111, WB writes reg 8 with 0xDEADBEEF -> ex_a=0xDEADBEEF. Repeat with macro off -> ex_a=0x11111111.
- Zero register: id_rs=0, id_rt=0, WB writes reg 0 with 0xFFFFFFFF, rf data 0 -> ex_a=ex_b=0.
- Stall: load an instruction, then stall=1 for 3 cycles while all inputs change -> outputs unchanged and bubble_count unchanged.
- Flush with stall: flush=1 and stall=1 together -> ex_valid=0, ex_ctrl=0, bubble_count+1. Then id_valid=0 for 2 cycles -> bubble_count+2 more.
- Saturation with CNT_W=4: 20 consecutive flushes -> bubble_count=15 and stays at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions for the ID/EX boundary and its helpers:
// datapath and register index widths, the hard-wired zero register index,
// the packed control bundle layout and the per-edge action of the stage.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 10;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // Bit positions inside the packed control bundle
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_REGDST    = 5;
    localparam int CTRL_BRANCH    = 6;
    localparam int CTRL_ALUOP_LSB = 7;
    localparam int CTRL_ALUOP_MSB = 9;

    // What the EX register bank does on the next rising edge
    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_LOAD
    } ex_action_e;

endpackage

// File: rtl/wb_bypass_sel.sv
// ---------------------------------------------------------------------------
// wb_bypass_sel
// Purely combinational operand selector for one register file read port.
// The register file writes on the clock edge, so a read in the same cycle as
// a WB write to that register returns the old value; this picks the WB data
// instead. Register 0 is hard-wired and never substituted.
// Ports:
//   idx_i             register index being read
//   rf_data_i         register file read data for idx_i
//   wb_write_enable_i WB write strobe
//   wb_write_reg_i    WB destination index
//   wb_write_data_i   WB data
//   sel_data_o        selected operand
// ---------------------------------------------------------------------------
module wb_bypass_sel #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] idx_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              wb_write_enable_i,
    input  logic [REG_AW-1:0] wb_write_reg_i,
    input  logic [DATA_W-1:0] wb_write_data_i,
    output logic [DATA_W-1:0] sel_data_o
);
    import pipe_pkg::*;

    logic bypassHit;

    assign bypassHit  = wb_write_enable_i && (wb_write_reg_i == idx_i) &&
                        (idx_i != REG_AW'(ZERO_REG));
    assign sel_data_o = bypassHit ? wb_write_data_i : rf_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register. Latches the decoded instruction, both register
// file read ports and the control bundle into EX with one cycle of latency.
// Supports stall (hold everything) and flush (load a bubble), and counts the
// bubbles it loads in a saturating counter.
// Build option: define ID_EX_WB_BYPASS_EN to substitute same-cycle WB data
// for stale register file reads; otherwise the wb_* ports are unused.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   stall, flush        hold request, bubble request (flush wins)
//   id_*                instruction fields from ID
//   rf_read_data1/2     register file reads addressed by id_rs / id_rt
//   wb_*                WB write port, same strobe as the register file
//   ex_*                registered EX fields, ex_a/ex_b are the operands
//   bubble_count        saturating count of bubbles loaded
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              wb_write_enable,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [CNT_W-1:0]  bubble_count
);
    import pipe_pkg::*;

    ex_action_e        action;
    logic              bubbleLoad;
    logic [DATA_W-1:0] operandA_d;
    logic [DATA_W-1:0] operandB_d;
    logic [CNT_W-1:0]  bubbleCount_d;

    logic              exValid_q;
    logic [DATA_W-1:0] exPc4_q;
    logic [REG_AW-1:0] exRs_q;
    logic [REG_AW-1:0] exRt_q;
    logic [REG_AW-1:0] exRd_q;
    logic [DATA_W-1:0] exImm_q;
    logic [CTRL_W-1:0] exCtrl_q;
    logic [DATA_W-1:0] exA_q;
    logic [DATA_W-1:0] exB_q;
    logic [CNT_W-1:0]  bubbleCount_q;

`ifdef ID_EX_WB_BYPASS_EN
    wb_bypass_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_a (
        .idx_i             (id_rs),
        .rf_data_i         (rf_read_data1),
        .wb_write_enable_i (wb_write_enable),
        .wb_write_reg_i    (wb_write_reg),
        .wb_write_data_i   (wb_write_data),
        .sel_data_o        (operandA_d)
    );

    wb_bypass_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_b (
        .idx_i             (id_rt),
        .rf_data_i         (rf_read_data2),
        .wb_write_enable_i (wb_write_enable),
        .wb_write_reg_i    (wb_write_reg),
        .wb_write_data_i   (wb_write_data),
        .sel_data_o        (operandB_d)
    );
`else
    // Without the bypass the integrator guarantees write-first reads, so the
    // WB port is deliberately left dangling.
    logic unusedWb;
    assign unusedWb   = ^{wb_write_enable, wb_write_reg, wb_write_data};
    assign operandA_d = rf_read_data1;
    assign operandB_d = rf_read_data2;
`endif

    // Edge priority: reset, then flush, then stall, otherwise load.
    // A bubble is either a flush or a load of an empty ID slot; the counter
    // sticks at all-ones instead of wrapping.
    always_comb begin
        action = ACT_LOAD;
        if (!reset) begin
            action = ACT_RESET;
        end else if (flush) begin
            action = ACT_FLUSH;
        end else if (stall) begin
            action = ACT_HOLD;
        end
        bubbleLoad    = (action == ACT_FLUSH) || ((action == ACT_LOAD) && !id_valid);
        bubbleCount_d = bubbleCount_q;
        if (bubbleLoad && (bubbleCount_q != '1)) begin
            bubbleCount_d = bubbleCount_q + CNT_W'(1);
        end
    end

    // EX register bank; an empty ID slot still latches its fields but the
    // control bundle is cleared so nothing downstream acts on it.
    always_ff @(posedge clk) begin
        case (action)
            ACT_RESET, ACT_FLUSH: begin
                exValid_q <= 1'b0;
                exPc4_q   <= '0;
                exRs_q    <= '0;
                exRt_q    <= '0;
                exRd_q    <= '0;
                exImm_q   <= '0;
                exCtrl_q  <= '0;
                exA_q     <= '0;
                exB_q     <= '0;
                bubbleCount_q <= (action == ACT_RESET) ? '0 : bubbleCount_d;
            end
            ACT_LOAD: begin
                exValid_q     <= id_valid;
                exPc4_q       <= id_pc4;
                exRs_q        <= id_rs;
                exRt_q        <= id_rt;
                exRd_q        <= id_rd;
                exImm_q       <= id_imm;
                exCtrl_q      <= id_valid ? id_ctrl : '0;
                exA_q         <= operandA_d;
                exB_q         <= operandB_d;
                bubbleCount_q <= bubbleCount_d;
            end
            default: begin
            end
        endcase
    end

    assign ex_valid     = exValid_q;
    assign ex_pc4       = exPc4_q;
    assign ex_rs        = exRs_q;
    assign ex_rt        = exRt_q;
    assign ex_rd        = exRd_q;
    assign ex_imm       = exImm_q;
    assign ex_ctrl      = exCtrl_q;
    assign ex_a         = exA_q;
    assign ex_b         = exB_q;
    assign bubble_count = bubbleCount_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. Two instances share all inputs: the
// default 16-bit bubble counter and a 4-bit one for saturation. A reference
// model of the EX contents is advanced on every rising edge and compared with
// both instances on every falling edge; directed steps pin literal values.
// Honours ID_EX_WB_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic              wb_write_enable;
    logic [REG_AW-1:0] wb_write_reg;
    logic [DATA_W-1:0] wb_write_data;

    logic              ex_valid,  d4_valid;
    logic [DATA_W-1:0] ex_pc4,    d4_pc4;
    logic [REG_AW-1:0] ex_rs,     d4_rs;
    logic [REG_AW-1:0] ex_rt,     d4_rt;
    logic [REG_AW-1:0] ex_rd,     d4_rd;
    logic [DATA_W-1:0] ex_imm,    d4_imm;
    logic [CTRL_W-1:0] ex_ctrl,   d4_ctrl;
    logic [DATA_W-1:0] ex_a,      d4_a;
    logic [DATA_W-1:0] ex_b,      d4_b;
    logic [15:0]       bubble_count;
    logic [3:0]        d4_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_write_enable(wb_write_enable), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_a(ex_a),
        .ex_b(ex_b), .bubble_count(bubble_count)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_write_enable(wb_write_enable), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_valid(d4_valid), .ex_pc4(d4_pc4), .ex_rs(d4_rs), .ex_rt(d4_rt),
        .ex_rd(d4_rd), .ex_imm(d4_imm), .ex_ctrl(d4_ctrl), .ex_a(d4_a),
        .ex_b(d4_b), .bubble_count(d4_count)
    );

    // Reference model of what EX must hold
    typedef struct {
        logic              valid;
        logic [DATA_W-1:0] pc4;
        logic [REG_AW-1:0] rs, rt, rd;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] a, b;
    } ex_model_t;

    ex_model_t m;
    int        mCount16 = 0;
    int        mCount4  = 0;
    bit        modelValid = 0;

    function automatic logic [DATA_W-1:0] expOperand(input logic [REG_AW-1:0] idx,
                                                     input logic [DATA_W-1:0] rfData);
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_write_enable && wb_write_reg == idx && idx != 0) return wb_write_data;
`endif
        return rfData;
    endfunction

    function automatic ex_model_t emptyEx();
        ex_model_t e;
        e.valid = 1'b0; e.pc4 = '0; e.rs = '0; e.rt = '0; e.rd = '0;
        e.imm = '0; e.ctrl = '0; e.a = '0; e.b = '0;
        return e;
    endfunction

    // Advance the model with the inputs present at each rising edge
    always begin
        @(posedge clk);
        if (!reset) begin
            m = emptyEx();
            mCount16 = 0;
            mCount4  = 0;
            modelValid = 1;
        end else if (flush) begin
            m = emptyEx();
            mCount16 = (mCount16 < 65535) ? mCount16 + 1 : 65535;
            mCount4  = (mCount4 < 15) ? mCount4 + 1 : 15;
        end else if (!stall) begin
            m.valid = id_valid;
            m.pc4   = id_pc4;
            m.rs    = id_rs;
            m.rt    = id_rt;
            m.rd    = id_rd;
            m.imm   = id_imm;
            m.ctrl  = id_valid ? id_ctrl : '0;
            m.a     = expOperand(id_rs, rf_read_data1);
            m.b     = expOperand(id_rt, rf_read_data2);
            if (!id_valid) begin
                mCount16 = (mCount16 < 65535) ? mCount16 + 1 : 65535;
                mCount4  = (mCount4 < 15) ? mCount4 + 1 : 15;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input string tag, input logic valid,
                              input logic [DATA_W-1:0] pc4, input logic [REG_AW-1:0] rs,
                              input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                              input logic [DATA_W-1:0] imm, input logic [CTRL_W-1:0] ctrl,
                              input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input int count, input int expCount);
        checkOutput({tag, ".ex_valid"}, 64'(valid), 64'(m.valid));
        checkOutput({tag, ".ex_pc4"},   64'(pc4),   64'(m.pc4));
        checkOutput({tag, ".ex_rs"},    64'(rs),    64'(m.rs));
        checkOutput({tag, ".ex_rt"},    64'(rt),    64'(m.rt));
        checkOutput({tag, ".ex_rd"},    64'(rd),    64'(m.rd));
        checkOutput({tag, ".ex_imm"},   64'(imm),   64'(m.imm));
        checkOutput({tag, ".ex_ctrl"},  64'(ctrl),  64'(m.ctrl));
        checkOutput({tag, ".ex_a"},     64'(a),     64'(m.a));
        checkOutput({tag, ".ex_b"},     64'(b),     64'(m.b));
        checkOutput({tag, ".bubble_count"}, 64'(count), 64'(expCount));
    endtask

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        if (modelValid) begin
            compareDut("main", ex_valid, ex_pc4, ex_rs, ex_rt, ex_rd, ex_imm, ex_ctrl,
                       ex_a, ex_b, int'(bubble_count), mCount16);
            compareDut("cnt4", d4_valid, d4_pc4, d4_rs, d4_rt, d4_rd, d4_imm, d4_ctrl,
                       d4_a, d4_b, int'(d4_count), mCount4);
        end
    end

    // Random instruction; indices drawn from a small range to provoke WB hits
    task automatic applyStimulus();
        id_valid        = 1'($urandom);
        id_pc4          = $urandom;
        id_rs           = REG_AW'($urandom_range(0, 3));
        id_rt           = REG_AW'($urandom_range(0, 3));
        id_rd           = REG_AW'($urandom);
        id_imm          = $urandom;
        id_ctrl         = CTRL_W'($urandom);
        rf_read_data1   = $urandom;
        rf_read_data2   = $urandom;
        wb_write_enable = 1'($urandom);
        wb_write_reg    = REG_AW'($urandom_range(0, 3));
        wb_write_data   = $urandom;
    endtask

    task automatic stepEdge();
        @(negedge clk);
    endtask

    task automatic runLoad();
        applyStimulus();
        reset = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b1;
    endtask

    logic [DATA_W-1:0] heldPc4;
    logic [DATA_W-1:0] expA;

    initial begin
        // Reset held for two edges with random inputs, including flush/stall
        applyStimulus();
        reset = 1'b0; flush = 1'($urandom); stall = 1'($urandom);
        stepEdge();
        applyStimulus();
        flush = 1'b1; stall = 1'b1;
        stepEdge();
        checkOutput("reset.ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("reset.ex_pc4", 64'(ex_pc4), 64'd0);
        checkOutput("reset.ex_a", 64'(ex_a), 64'd0);
        checkOutput("reset.bubble_count", 64'(bubble_count), 64'd0);

        // First load after release
        runLoad();
        id_pc4 = 32'h0040_0004;
        stepEdge();
        checkOutput("load.ex_pc4", 64'(ex_pc4), 64'h0040_0004);
        checkOutput("load.ex_valid", 64'(ex_valid), 64'd1);

        // WB to the register being read in the same cycle
        runLoad();
        id_rs = 5'd8; rf_read_data1 = 32'h1111_1111;
        wb_write_enable = 1'b1; wb_write_reg = 5'd8; wb_write_data = 32'hDEAD_BEEF;
        stepEdge();
`ifdef ID_EX_WB_BYPASS_EN
        expA = 32'hDEAD_BEEF;
`else
        expA = 32'h1111_1111;
`endif
        checkOutput("bypass.ex_a", 64'(ex_a), 64'(expA));

        // Register 0 is never substituted
        runLoad();
        id_rs = 5'd0; id_rt = 5'd0; rf_read_data1 = '0; rf_read_data2 = '0;
        wb_write_enable = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'hFFFF_FFFF;
        stepEdge();
        checkOutput("zero.ex_a", 64'(ex_a), 64'd0);
        checkOutput("zero.ex_b", 64'(ex_b), 64'd0);

        // Stall holds everything while inputs churn
        runLoad();
        heldPc4 = id_pc4;
        stepEdge();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            reset = 1'b1; flush = 1'b0; stall = 1'b1;
            stepEdge();
            checkOutput("stall.ex_pc4", 64'(ex_pc4), 64'(heldPc4));
            checkOutput("stall.ex_valid", 64'(ex_valid), 64'd1);
            checkOutput("stall.bubble_count", 64'(bubble_count), 64'd0);
        end

        // Flush beats stall, then two empty ID slots
        applyStimulus();
        reset = 1'b1; flush = 1'b1; stall = 1'b1;
        stepEdge();
        checkOutput("flush.ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("flush.ex_ctrl", 64'(ex_ctrl), 64'd0);
        checkOutput("flush.bubble_count", 64'(bubble_count), 64'd1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            reset = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
            stepEdge();
        end
        checkOutput("empty.bubble_count", 64'(bubble_count), 64'd3);
        checkOutput("empty.ex_ctrl", 64'(ex_ctrl), 64'd0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            reset = 1'b1; flush = 1'b1; stall = 1'($urandom);
            stepEdge();
        end
        checkOutput("sat.cnt4", 64'(d4_count), 64'd15);
        checkOutput("sat.cnt16", 64'(bubble_count), 64'd23);
        runLoad();
        flush = 1'b1;
        stepEdge();
        checkOutput("sat.cnt4_hold", 64'(d4_count), 64'd15);

        // Random traffic with occasional reset, stall and flush
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            reset = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stepEdge();
        end

        stepEdge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
